i2s_unit: RTL and testbench
===========================

# i2s_unit

Serial output stage of the audioport, clocked in the mclk domain. Consumes the synchronized stereo samples (mdsp, mtick, mplay) that the clock-domain crossing delivers from the dsp_unit. Double-buffers each sample and shifts it out as a standard I2S master stream on sck_out, ws_out and sdo_out. Raises req_out each time its input buffer frees up, so the upstream stage can deliver the next sample.

## Interface
Parameters:
- SCK_DIV, 4: mclk cycles per sck period. Must be even and ≥2.

Ports:
- clk  in  1  mclk-domain clock; top level connects mclk.
- rst_n  in  1  asynchronous active-low reset; top level connects mrst_n.
- play_in  in  1  level; 1 = playback enabled (mplay).
- tick_in  in  1  one-cycle strobe; audio0_in/audio1_in are valid in this cycle (mtick).
- audio0_in  in  24  left sample, two's complement.
- audio1_in  in  24  right sample, two's complement.
- req_out  out  1  one-cycle pulse requesting the next sample (mreq).
- sck_out  out  1  I2S bit clock.
- ws_out  out  1  word select; 0 = left, 1 = right.
- sdo_out  out  1  serial data, MSB first.

## Operation
- Reset: all outputs are 0, state STOP, buffer empty, all counters 0.
- State STOP: sck_out, ws_out and sdo_out are held at 0. On play_in=1, go to WAIT and pulse req_out in the next cycle.
- State WAIT: sck_out is held at 0.
  - tick_in=1 loads {audio0_in, audio1_in} into the input buffer and sets buf_valid.
  - If buf_valid=1, go to RUN in the next cycle.
  - If play_in falls, go to STOP.
- State RUN: the frame is 64 sck periods, bit index b=0..63.
  - At each b=0 start, move the buffer into the 48-bit shift register, clear buf_valid and pulse req_out.
  - sdo_out is the left bit 23-(b-1) for b=1..24 and the right bit 23-(b-33) for b=33..56. It is 0 for every other b (one-bit I2S delay).
  - ws_out=1 for b=31..62, otherwise 0.
  - tick_in while buf_valid=1 overwrites the buffer (latest sample wins).
  - tick_in in the same cycle as the frame-start load: the shift register takes the old buffer contents; the buffer takes the new sample and buf_valid stays 1.
- Underrun: buf_valid=0 at a frame start. The frame is still emitted; see Configuration for its contents. req_out still pulses.
- Stop: play_in=0 while in RUN completes the current frame through b=63, then goes to STOP and clears buf_valid. A new play_in=1 during this drain is ignored until STOP is reached.
- The asynchronous reset mid-frame returns immediately to the reset values.

## Timing
- Divider counter runs 0..SCK_DIV-1 in RUN only. sck_out=1 when the counter ≥ SCK_DIV/2.
- sdo_out and ws_out change only in the cycle where the counter wraps to 0 (sck falling edge). The receiver samples on the sck rising edge.
- b increments at each counter wrap and wraps 63→0. Frame length = 64·SCK_DIV mclk cycles (256 at default).
- All outputs are registered.
- From the play_in rise to the first req_out: 1 cycle.
- From a tick_in in WAIT to the first sck_out rise: SCK_DIV/2+1 cycles.

## Configuration
- I2S_UNDERRUN_REPEAT_EN defined: an underrun frame re-sends the previous frame's samples. Keep a 48-bit last-sample register, zeroed at reset and on entry to STOP.
- Not defined: an underrun frame sends all-zero data. ws_out and sck_out are unchanged.

## Structure
- audioport_pkg holds:
  - AUDIO_BITS=24
  - I2S_FRAME_BITS=64
  - I2S_SLOT_BITS=32
  - typedef enum i2s_state_t {STOP, WAIT, RUN}
- Sub-module i2s_sck_divider: owns the divider counter and produces sck_out plus a fall-edge strobe. The shift and frame logic stays in i2s_unit.

## Test plan
- Reset, then play_in=0 for 1000 cycles → all outputs 0, no req_out.
- play_in↑, tick_in with audio0=24'h800001, audio1=24'h7FFFFE → req_out at +1 cycle. sdo_out captured on sck rises gives slot L=0x800001, slot R=0x7FFFFE, 8 pad zeros each. ws_out toggles at b=31 and b=63.
- Continuous tick_in once per req_out → exactly one req_out per 256 cycles and no gaps in sck_out.
- Withhold tick_in for one frame → with the macro, that frame repeats the previous samples; without it, sdo_out=0 for all 64 bits.
- play_in↓ at b=10 → the frame completes through b=63, then sck_out, ws_out and sdo_out stay 0. A play_in pulse during the drain is ignored.
- rst_n asserted at b=40 → all outputs 0 in the same cycle. After release with play_in=1, a fresh req_out is issued.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared constants and types for the audioport serial output stage.
package audioport_pkg;

    localparam int AUDIO_BITS     = 24;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_BITS  = 32;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } i2s_state_t;

    // One stereo sample as it sits in the input buffer: left in the upper half.
    typedef struct packed {
        logic [AUDIO_BITS-1:0] left;
        logic [AUDIO_BITS-1:0] right;
    } i2s_sample_t;

    // Word select for bit period b: high from one bit before the right slot
    // until one bit before the next frame (I2S one-bit lead).
    function automatic logic i2s_ws_bit(input logic [5:0] b);
        return (b >= 6'd31) && (b <= 6'd62);
    endfunction

    // Bit periods that carry sample data; everything else is padding zero.
    function automatic logic i2s_data_bit(input logic [5:0] b);
        return ((b >= 6'd1)  && (b <= 6'd24)) ||
               ((b >= 6'd33) && (b <= 6'd56));
    endfunction

endpackage

// File: rtl/i2s_sck_divider.sv
// Bit-clock divider for i2s_unit. Counts 0..SCK_DIV-1 while enabled and
// sits at 0 otherwise; sck_out is high for the upper half of the count.
// SCK_DIV must be even and >= 2.
module i2s_sck_divider #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck_out,
    output logic fall_stb,
    output logic phase0
);

    localparam int            CW   = $clog2(SCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(SCK_DIV / 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next count: parked at 0 when disabled, wraps at the end of each period.
    always_comb begin
        cnt_nxt = '0;
        if (en && (cnt != LAST))
            cnt_nxt = cnt + 1'b1;
    end

    // Counter and registered bit clock, so sck_out tracks the count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sck_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            sck_out <= (cnt_nxt >= HALF);
        end
    end

    // fall_stb marks the cycle whose closing edge is the sck falling edge.
    assign fall_stb = en && (cnt == LAST);
    assign phase0   = (cnt == '0);

endmodule

// File: rtl/i2s_unit.sv
// I2S master output stage (mclk domain). Double-buffers stereo samples
// delivered on tick_in and shifts them out as 64-bit I2S frames.
// Optional feature: define I2S_UNDERRUN_REPEAT_EN to repeat the previous
// frame's samples on underrun instead of sending zeros.
module i2s_unit
    import audioport_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play_in,
    input  logic                  tick_in,
    input  logic [AUDIO_BITS-1:0] audio0_in,
    input  logic [AUDIO_BITS-1:0] audio1_in,
    output logic                  req_out,
    output logic                  sck_out,
    output logic                  ws_out,
    output logic                  sdo_out
);

    localparam int SW = 2 * AUDIO_BITS;

    i2s_state_t    state;
    logic          drain;
    i2s_sample_t   buf_q;
    logic          buf_valid;
    logic [SW-1:0] shreg;
    logic [SW-1:0] fill;
    logic [5:0]    bit_idx;
    logic [5:0]    bit_nxt;
    i2s_sample_t   sample_in;

    logic run;
    logic fall;
    logic phase0;
    logic frame_start;
    logic frame_end;
    logic stop_now;
    logic go_stop;

    assign sample_in.left  = audio0_in;
    assign sample_in.right = audio1_in;

    assign run         = (state == RUN);
    assign bit_nxt     = bit_idx + 6'd1;
    assign frame_start = run && phase0 && (bit_idx == 6'd0);
    assign frame_end   = fall && (bit_idx == 6'(I2S_FRAME_BITS - 1));
    // A stop request seen in the very last cycle still ends the frame cleanly.
    assign stop_now    = frame_end && (drain || !play_in);
    assign go_stop     = stop_now || ((state == WAIT) && !play_in);

    i2s_sck_divider #(
        .SCK_DIV (SCK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run),
        .sck_out  (sck_out),
        .fall_stb (fall),
        .phase0   (phase0)
    );

`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [SW-1:0] last_q;

    // Remember what the last real frame carried so an underrun can replay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= '0;
        else if (go_stop)
            last_q <= '0;
        else if (frame_start && buf_valid)
            last_q <= buf_q;
    end

    assign fill = last_q;
`else
    assign fill = '0;
`endif

    // Playback FSM. Entering RUN on the loading tick itself keeps the first
    // sck rise SCK_DIV/2+1 cycles after that tick. Once a stop is requested
    // in RUN, the drain flag holds it until the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOP;
            drain <= 1'b0;
        end else begin
            case (state)
                STOP: begin
                    drain <= 1'b0;
                    if (play_in)
                        state <= WAIT;
                end
                WAIT: begin
                    if (!play_in)
                        state <= STOP;
                    else if (tick_in || buf_valid)
                        state <= RUN;
                end
                RUN: begin
                    if (stop_now) begin
                        state <= STOP;
                        drain <= 1'b0;
                    end else if (!play_in) begin
                        drain <= 1'b1;
                    end
                end
                default: begin
                    state <= STOP;
                    drain <= 1'b0;
                end
            endcase
        end
    end

    // Sample request: once when playback is armed, then once per frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            req_out <= 1'b0;
        else
            req_out <= ((state == STOP) && play_in) || frame_start;
    end

    // Input buffer. A tick always wins (latest sample), even in the frame-start
    // cycle where the shift register takes the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            buf_valid <= 1'b0;
        end else if (go_stop || (state == STOP)) begin
            buf_valid <= 1'b0;
        end else if (tick_in) begin
            buf_q     <= sample_in;
            buf_valid <= 1'b1;
        end else if (frame_start) begin
            buf_valid <= 1'b0;
        end
    end

    // Bit index within the frame; advances on each sck falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_idx <= '0;
        else if (!run)
            bit_idx <= '0;
        else if (fall)
            bit_idx <= bit_nxt;
    end

    // Frame serializer: load at frame start, then update ws/sdo only on the
    // falling edge for the bit period that is about to begin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            ws_out  <= 1'b0;
            sdo_out <= 1'b0;
        end else if (!run) begin
            ws_out  <= 1'b0;
            sdo_out <= 1'b0;
        end else if (frame_start) begin
            shreg <= buf_valid ? SW'(buf_q) : fill;
        end else if (fall) begin
            ws_out <= i2s_ws_bit(bit_nxt);
            if (i2s_data_bit(bit_nxt)) begin
                sdo_out <= shreg[SW-1];
                shreg   <= {shreg[SW-2:0], 1'b0};
            end else begin
                sdo_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_unit.sv
`timescale 1ns/1ps
module tb_i2s_unit;

    localparam int DIV   = 4;
    localparam int HALF  = DIV / 2;
    localparam int FRAME = 64 * DIV;
`ifdef I2S_UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [23:0] audio0_in = '0;
    logic [23:0] audio1_in = '0;
    logic        req_out, sck_out, ws_out, sdo_out;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    logic   sck_q = 1'b0;

    logic   cap_sdo[$];
    logic   cap_ws[$];
    longint rise_t[$];
    longint req_t[$];

    i2s_unit #(.SCK_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play_in   (play_in),
        .tick_in   (tick_in),
        .audio0_in (audio0_in),
        .audio1_in (audio1_in),
        .req_out   (req_out),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .sdo_out   (sdo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: latch sdo/ws on every sck rise, log req pulses.
    always @(negedge clk) begin
        if (sck_out && !sck_q) begin
            cap_sdo.push_back(sdo_out);
            cap_ws.push_back(ws_out);
            rise_t.push_back(cyc);
        end
        if (req_out) req_t.push_back(cyc);
        sck_q = sck_out;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected frame from the I2S rules: left MSB at b=1, right MSB at b=33.
    function automatic logic [63:0] exp_sdo(input logic [47:0] pl);
        logic [63:0] v;
        v = '0;
        for (int b = 1; b <= 24; b++)  v[b] = pl[24 + 23 - (b - 1)];
        for (int b = 33; b <= 56; b++) v[b] = pl[23 - (b - 33)];
        return v;
    endfunction

    function automatic logic [63:0] exp_ws();
        logic [63:0] v;
        v = '0;
        for (int b = 31; b <= 62; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] got_sdo(input int f);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 64; b++)
            if (64 * f + b < cap_sdo.size()) v[b] = cap_sdo[64 * f + b];
        return v;
    endfunction

    function automatic logic [63:0] got_ws(input int f);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 64; b++)
            if (64 * f + b < cap_ws.size()) v[b] = cap_ws[64 * f + b];
        return v;
    endfunction

    function automatic logic [47:0] rnd48();
        return {24'($urandom), 24'($urandom)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_clear();
        cap_sdo.delete();
        cap_ws.delete();
        rise_t.delete();
        req_t.delete();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        play_in = 1'b0;
        tick_in = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        mon_clear();
    endtask

    task automatic wait_req(output longint t);
        int n;
        n = 0;
        while (!req_out && n < 2 * FRAME) begin
            step(1);
            n++;
        end
        t = cyc;
        checks++;
        if (!req_out) begin
            errors++;
            $display("FAIL req_timeout: no req_out within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic send(input logic [47:0] pl);
        audio0_in = pl[47:24];
        audio1_in = pl[23:0];
        tick_in   = 1'b1;
        step(1);
        tick_in   = 1'b0;
        audio0_in = 24'($urandom);
        audio1_in = 24'($urandom);
    endtask

    task automatic wait_rises(input int n);
        int k;
        k = 0;
        while (cap_sdo.size() < n && k < n * DIV + 4 * FRAME) begin
            step(1);
            k++;
        end
        checks++;
        if (cap_sdo.size() < n) begin
            errors++;
            $display("FAIL rise_timeout: got %0d sck rises, need %0d", cap_sdo.size(), n);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n   = 1'b0;
        play_in = 1'b0;
        step(2);
        checks++;
        if ({req_out, sck_out, ws_out, sdo_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000", {req_out, sck_out, ws_out, sdo_out});
        end
        rst_n = 1'b1;
        mon_clear();
        bad = 0;
        repeat (1000) begin
            step(1);
            if ({req_out, sck_out, ws_out, sdo_out} !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d nonzero cycles, want 0", bad);
        end
        checks++;
        if (req_t.size() != 0) begin
            errors++;
            $display("FAIL idle_req: %0d req pulses, want 0", req_t.size());
        end
    endtask

    task automatic test_basic();
        longint      p, t, t0, t1;
        logic [47:0] pl [2];
        do_reset();
        pl[0] = 48'h800001_7FFFFE;
        pl[1] = rnd48();
        p = cyc;
        play_in = 1'b1;
        wait_req(t);
        checks++;
        if (t - p != 1) begin
            errors++;
            $display("FAIL play_to_req: got %0d cycles want 1", t - p);
        end
        t0 = cyc;
        send(pl[0]);
        wait_req(t1);
        checks++;
        if (t1 - t0 != 2) begin
            errors++;
            $display("FAIL first_frame_req: got %0d cycles after tick want 2", t1 - t0);
        end
        send(pl[1]);
        wait_rises(128);
        checks++;
        if (rise_t.size() == 0 || rise_t[0] - t0 != HALF + 1) begin
            errors++;
            $display("FAIL tick_to_sck: got %0d want %0d", rise_t.size() ? rise_t[0] - t0 : -1, HALF + 1);
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (got_sdo(f) !== exp_sdo(pl[f])) begin
                errors++;
                $display("FAIL basic_sdo f%0d: got %h want %h", f, got_sdo(f), exp_sdo(pl[f]));
            end
            checks++;
            if (got_ws(f) !== exp_ws()) begin
                errors++;
                $display("FAIL basic_ws f%0d: got %h want %h", f, got_ws(f), exp_ws());
            end
        end
    endtask

    task automatic test_continuous();
        localparam int N = 6;
        longint      t;
        logic [47:0] pl [N];
        int          bad;
        do_reset();
        play_in = 1'b1;
        for (int f = 0; f < N; f++) begin
            wait_req(t);
            step(int'($urandom_range(0, (f == 0) ? 5 : FRAME - 40)));
            pl[f] = rnd48();
            send(pl[f]);
        end
        wait_rises(64 * N);
        for (int f = 0; f < N; f++) begin
            checks++;
            if (got_sdo(f) !== exp_sdo(pl[f])) begin
                errors++;
                $display("FAIL cont_sdo f%0d: got %h want %h", f, got_sdo(f), exp_sdo(pl[f]));
            end
            checks++;
            if (got_ws(f) !== exp_ws()) begin
                errors++;
                $display("FAIL cont_ws f%0d: got %h want %h", f, got_ws(f), exp_ws());
            end
        end
        for (int i = 1; i < N; i++) begin
            checks++;
            if (i + 1 >= req_t.size() || req_t[i + 1] - req_t[i] != FRAME) begin
                errors++;
                $display("FAIL req_period %0d: got %0d want %0d", i,
                         (i + 1 < req_t.size()) ? req_t[i + 1] - req_t[i] : -1, FRAME);
            end
        end
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++)
            if (rise_t[i] - rise_t[i - 1] != DIV) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sck_gaps: %0d irregular sck periods, want 0", bad);
        end
    endtask

    task automatic test_underrun();
        longint      t, t2;
        logic [47:0] pl [6];
        logic [47:0] x;
        do_reset();
        play_in = 1'b1;
        wait_req(t);
        pl[0] = rnd48();
        send(pl[0]);
        // frame 1: two ticks, the later one must be sent
        wait_req(t);
        step(int'($urandom_range(0, 50)));
        x = rnd48();
        send(x);
        step(int'($urandom_range(1, 50)));
        pl[1] = rnd48();
        send(pl[1]);
        // frame 2 from a normal tick; a second tick lands exactly on frame 2's start
        wait_req(t2);
        step(int'($urandom_range(0, 50)));
        pl[2] = rnd48();
        send(pl[2]);
        step(int'((t2 + FRAME - 1) - cyc));
        pl[3] = rnd48();
        send(pl[3]);
        wait_req(t);
        checks++;
        if (t != t2 + FRAME) begin
            errors++;
            $display("FAIL start_tick_req: got cycle %0d want %0d", t, t2 + FRAME);
        end
        // frame 3 comes from the buffered start-cycle tick; frame 4 underruns
        step(1);
        wait_req(t);
        step(1);
        wait_req(t);
        pl[4] = REPEAT ? pl[3] : 48'h0;
        pl[5] = rnd48();
        send(pl[5]);
        wait_rises(64 * 6);
        for (int f = 0; f < 6; f++) begin
            checks++;
            if (got_sdo(f) !== exp_sdo(pl[f])) begin
                errors++;
                $display("FAIL underrun_sdo f%0d: got %h want %h", f, got_sdo(f), exp_sdo(pl[f]));
            end
            checks++;
            if (got_ws(f) !== exp_ws()) begin
                errors++;
                $display("FAIL underrun_ws f%0d: got %h want %h", f, got_ws(f), exp_ws());
            end
        end
    endtask

    task automatic test_stop_drain();
        longint      t, t2, p;
        logic [47:0] pl [3];
        int          bad;
        do_reset();
        play_in = 1'b1;
        for (int f = 0; f < 3; f++) pl[f] = rnd48();
        wait_req(t);
        send(pl[0]);
        wait_req(t);
        send(pl[1]);
        wait_req(t2);
        send(pl[2]);
        // drop play at b=10 of frame 1, pulse it again at b=30
        step(int'((t2 - 1 + 10 * DIV) - cyc));
        play_in = 1'b0;
        step(20 * DIV);
        play_in = 1'b1;
        step(2);
        play_in = 1'b0;
        step(3 * FRAME);
        checks++;
        if (cap_sdo.size() != 128) begin
            errors++;
            $display("FAIL drain_rises: got %0d want 128", cap_sdo.size());
        end
        checks++;
        if (rise_t.size() < 128 || rise_t[127] != t2 - 1 + 63 * DIV + HALF) begin
            errors++;
            $display("FAIL drain_last_rise: got %0d want %0d",
                     (rise_t.size() >= 128) ? rise_t[127] : -1, t2 - 1 + 63 * DIV + HALF);
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (got_sdo(f) !== exp_sdo(pl[f])) begin
                errors++;
                $display("FAIL drain_sdo f%0d: got %h want %h", f, got_sdo(f), exp_sdo(pl[f]));
            end
        end
        checks++;
        if (req_t.size() != 3) begin
            errors++;
            $display("FAIL drain_req_count: got %0d want 3", req_t.size());
        end
        bad = 0;
        repeat (300) begin
            step(1);
            if ({req_out, sck_out, ws_out, sdo_out} !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stopped_outputs: %0d nonzero cycles want 0", bad);
        end
        p = cyc;
        play_in = 1'b1;
        wait_req(t);
        checks++;
        if (t - p != 1) begin
            errors++;
            $display("FAIL restart_req: got %0d cycles want 1", t - p);
        end
    endtask

    task automatic test_reset_midframe();
        longint      t, t2, r;
        logic [47:0] q;
        do_reset();
        play_in = 1'b1;
        wait_req(t);
        send(rnd48());
        wait_req(t);
        send(rnd48());
        wait_req(t2);
        send(rnd48());
        step(int'((t2 - 1 + 40 * DIV + 1) - cyc));
        checks++;
        if (ws_out !== 1'b1) begin
            errors++;
            $display("FAIL ws_at_b40: got %b want 1", ws_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_out, sck_out, ws_out, sdo_out} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b want 0000", {req_out, sck_out, ws_out, sdo_out});
        end
        step(3);
        mon_clear();
        r = cyc;
        rst_n = 1'b1;
        wait_req(t);
        checks++;
        if (t != r + 1) begin
            errors++;
            $display("FAIL post_reset_req: got cycle %0d want %0d", t, r + 1);
        end
        q = rnd48();
        send(q);
        wait_rises(64);
        checks++;
        if (got_sdo(0) !== exp_sdo(q)) begin
            errors++;
            $display("FAIL post_reset_sdo: got %h want %h", got_sdo(0), exp_sdo(q));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_continuous();
        test_underrun();
        test_stop_drain();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
